// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, fixed WIDTH-cycle latency.
// Divide-by-zero completes immediately with quotient all ones and remainder equal to the dividend.
module seq_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] dvd_q;   // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] rem_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH:0]   partial;
   logic [WIDTH+1:0] trial;
   logic             no_borrow;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;
   logic             accept;
   logic             last_step;
   logic             unused_trial;

   // Trial subtract as partial + ~divisor + 1; the carry out of bit WIDTH means no borrow.
   always_comb begin
      partial   = {rem_q, dvd_q[WIDTH-1]};
      trial     = {1'b0, partial} + {1'b0, 1'b1, ~dvs_q} + (WIDTH+2)'(1);
      no_borrow = trial[WIDTH+1];
      rem_next  = no_borrow ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
      quo_next  = {dvd_q[WIDTH-2:0], no_borrow};
      accept    = start && (state_q != StCalc);
      last_step = (cnt_q == CW'(WIDTH - 1));
   end

   // A kept difference is always below the divisor, so its top bit is zero.
   assign unused_trial = trial[WIDTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         dvd_q <= dividend;
         dvs_q <= divisor;
         rem_q <= '0;
         cnt_q <= '0;
         if (divisor == '0) begin
            state_q     <= StDone;
            quotient    <= '1;
            remainder   <= dividend;
            busy        <= 1'b0;
            done        <= 1'b1;
            div_by_zero <= 1'b1;
         end else begin
            state_q     <= StCalc;
            busy        <= 1'b1;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
         end
      end else if (state_q == StCalc) begin
         dvd_q <= quo_next;
         rem_q <= rem_next;
         cnt_q <= cnt_q + CW'(1);
         if (last_step) begin
            state_q   <= StDone;
            quotient  <= quo_next;
            remainder <= rem_next;
            busy      <= 1'b0;
            done      <= 1'b1;
         end
      end else begin
         state_q <= StIdle;
         done    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: expected results are queued at issue time and checked by a
// monitor whenever done pulses, including the cycle in which done arrives.
module tb_seq_divider;

   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           due;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb[$];
   exp_t mon_e;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done at cycle %0d", cyc);
         end else begin
            mon_e = sb.pop_front();
            if (quotient !== mon_e.q) begin
               errors++;
               $display("FAIL quotient got %0d expected %0d", quotient, mon_e.q);
            end
            checks++;
            if (remainder !== mon_e.r) begin
               errors++;
               $display("FAIL remainder got %0d expected %0d", remainder, mon_e.r);
            end
            checks++;
            if (div_by_zero !== mon_e.dbz) begin
               errors++;
               $display("FAIL div_by_zero got %b expected %b", div_by_zero, mon_e.dbz);
            end
            checks++;
            if (cyc !== mon_e.due) begin
               errors++;
               $display("FAIL latency done at cycle %0d expected %0d", cyc, mon_e.due);
            end
         end
      end
   end

   // Called at a negedge while the DUT is idle or done; returns one cycle after acceptance.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.q   = (b == 0) ? {W{1'b1}} : a / b;
      e.r   = (b == 0) ? a : a % b;
      e.dbz = (b == 0);
      e.due = cyc + 1 + ((b == 0) ? 0 : W);
      sb.push_back(e);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
   endtask

   task automatic wait_done(input string name);
      for (int k = 0; k < W + 4 && done !== 1'b1; k++) @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s timeout done=%b expected 1", name, done);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 3 * W && sb.size() != 0; k++) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got q=%0d r=%0d b=%b d=%b z=%b expected all 0",
                  quotient, remainder, busy, done, div_by_zero);
      end
      start    = 1'b1;
      dividend = 8'd10;
      divisor  = 8'd2;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_priority busy=%b done=%b expected 0 0", busy, done);
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int nbusy = 0;
      issue(8'd100, 8'd7);
      for (int k = 0; k < 20 && done !== 1'b1; k++) begin
         if (busy === 1'b1) nbusy++;
         @(negedge clk);
      end
      checks++;
      if (nbusy != W) begin
         errors++;
         $display("FAIL busy_cycles got %0d expected %0d", nbusy, W);
      end
      drain();
   endtask

   task automatic test_vectors();
      issue(8'd255, 8'd1); drain();
      issue(8'd5, 8'd9);   drain();
      issue(8'd0, 8'd13);  drain();
      issue(8'd254, 8'd255); drain();
   endtask

   task automatic test_div_zero();
      issue(8'd42, 8'd0);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL dbz_busy got %b expected 0", busy);
      end
      @(negedge clk);
      checks++;
      if (div_by_zero !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL dbz_hold flag=%b done=%b expected 1 0", div_by_zero, done);
      end
      drain();
   endtask

   task automatic test_start_in_calc();
      int dc;
      issue(8'd200, 8'd3);
      repeat (2) @(negedge clk);
      start    = 1'b1;
      dividend = 8'd9;
      divisor  = 8'd9;
      @(negedge clk);
      start = 1'b0;
      wait_done("first_op");
      dc = cyc;
      issue(8'd9, 8'd9);
      wait_done("second_op");
      checks++;
      if (cyc - dc != W + 1) begin
         errors++;
         $display("FAIL restart_gap got %0d expected %0d", cyc - dc, W + 1);
      end
      drain();
   endtask

   task automatic test_reset_mid_calc();
      int ndone = 0;
      issue(8'd77, 8'd5);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      checks++;
      if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
         errors++;
         $display("FAIL abort_outputs got q=%0d r=%0d b=%b d=%b z=%b expected all 0",
                  quotient, remainder, busy, done, div_by_zero);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 2 * W; k++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL abort_done got %0d pulses expected 0", ndone);
      end
      issue(8'd77, 8'd5);
      drain();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a;
      logic [W-1:0] b;
      for (int n = 0; n < 3000; n++) begin
         a = W'($urandom);
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 3));
            default: b = W'($urandom);
         endcase
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         issue(a, b);
         wait_done("random_op");
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_div_zero();
      test_start_in_calc();
      test_reset_mid_calc();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
